// File: rtl/seg_pkg.sv
// Glyph table, digit codes and decoder state encoding shared by the seven-segment
// display driver and the readback decoder.
package seg_pkg;

    localparam int SEG_CODE_W = 5;

    localparam logic [SEG_CODE_W-1:0] CODE_R     = 5'd16;
    localparam logic [SEG_CODE_W-1:0] CODE_BLANK = 5'd17;
    localparam logic [SEG_CODE_W-1:0] CODE_BAD   = 5'd31;

    // Active-low g..a patterns; bit 6 is segment g.
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h27;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_R     = 7'h2F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment glyph to digit-code decoder; unknown glyphs map to CODE_BAD.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0]            pattern,
    output logic [SEG_CODE_W-1:0] code
);

    always_comb begin
        case (pattern)
            GLYPH_0:     code = 5'd0;
            GLYPH_1:     code = 5'd1;
            GLYPH_2:     code = 5'd2;
            GLYPH_3:     code = 5'd3;
            GLYPH_4:     code = 5'd4;
            GLYPH_5:     code = 5'd5;
            GLYPH_6:     code = 5'd6;
            GLYPH_7:     code = 5'd7;
            GLYPH_8:     code = 5'd8;
            GLYPH_9:     code = 5'd9;
            GLYPH_A:     code = 5'd10;
            GLYPH_B:     code = 5'd11;
            GLYPH_C:     code = 5'd12;
            GLYPH_D:     code = 5'd13;
            GLYPH_E:     code = 5'd14;
            GLYPH_F:     code = 5'd15;
            GLYPH_R:     code = CODE_R;
            GLYPH_BLANK: code = CODE_BLANK;
            default:     code = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg_frame_decoder.sv
// Debounces a multiplexed seven-segment bus and emits one snapshot per complete frame.
// Decimal-point readback is built only when SEG_DECODE_DP_EN is defined.
module seg_frame_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         ac,
    input  logic [DIGITS-1:0]            dig_sel,
    input  logic [7:0]                   seg_in,
    output logic                         frame_valid,
    output logic [SEG_CODE_W*DIGITS-1:0] frame_digits,
    output logic [DIGITS-1:0]            frame_dp,
    output logic                         frame_err,
    output logic [1:0]                   fsm_state
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    localparam logic [1:0] ST_SYNC    = SYNC;
    localparam logic [1:0] ST_COLLECT = COLLECT;
    localparam logic [1:0] ST_EMIT    = EMIT;

`ifdef SEG_DECODE_DP_EN
    localparam logic [7:0] CMP_MASK = 8'hFF;
`else
    localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

    logic [DIGITS-1:0]            s_sel, p_sel, filled, filled_next;
    logic [7:0]                   s_seg, p_seg;
    logic [CNT_W-1:0]             cnt, cnt_next;
    logic [1:0]                   state;
    logic                         pend, pend_next;
    logic                         same, blank, onehot, reach, commit, bad;
    logic                         accept, dup, full, any_bad;
    logic [SEG_CODE_W-1:0]        code;
    logic [SEG_CODE_W*DIGITS-1:0] hold, hold_next;

    seg_pattern_decode u_decode (
        .pattern (s_seg[6:0]),
        .code    (code)
    );

    assign same   = (s_sel == p_sel) && ((s_seg & CMP_MASK) == (p_seg & CMP_MASK));
    assign blank  = (s_sel == '0);
    assign onehot = !blank && ((s_sel & (s_sel - DIGITS'(1))) == '0);

    // A run commits once, on the sample that brings the count up to STABLE_CYCLES.
    assign reach  = !blank && same && (cnt == CNT_LAST);
    assign commit = reach && onehot;
    assign bad    = reach && !onehot;

    assign accept      = commit && ((state == ST_COLLECT) || ((state == ST_SYNC) && s_sel[0]));
    assign dup         = accept && (state == ST_COLLECT) && ((filled & s_sel) != '0);
    assign filled_next = accept ? (filled | s_sel) : filled;
    assign pend_next   = pend | dup | (bad && (state == ST_COLLECT));
    assign full        = accept && (filled_next == '1);

    always_comb begin
        if (blank)               cnt_next = '0;
        else if (!same)          cnt_next = CNT_W'(1);
        else if (cnt == CNT_MAX) cnt_next = cnt;
        else                     cnt_next = cnt + CNT_W'(1);
    end

    always_comb begin
        hold_next = hold;
        any_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (accept && s_sel[i]) hold_next[SEG_CODE_W*i +: SEG_CODE_W] = code;
            if (hold_next[SEG_CODE_W*i +: SEG_CODE_W] == CODE_BAD) any_bad = 1'b1;
        end
    end

    // The snapshot is loaded on the final commit edge, so the EMIT cycle is the pulse cycle.
    always_ff @(posedge clk) begin
        if (ac) begin
            s_sel        <= '0;
            s_seg        <= '0;
            p_sel        <= '0;
            p_seg        <= '0;
            cnt          <= '0;
            state        <= ST_SYNC;
            filled       <= '0;
            pend         <= 1'b0;
            hold         <= {DIGITS{CODE_BLANK}};
            frame_valid  <= 1'b0;
            frame_digits <= {DIGITS{CODE_BLANK}};
            frame_err    <= 1'b0;
        end else begin
            s_sel       <= dig_sel;
            s_seg       <= seg_in;
            p_sel       <= s_sel;
            p_seg       <= s_seg;
            cnt         <= cnt_next;
            frame_valid <= 1'b0;
            case (state)
                ST_SYNC, ST_COLLECT: begin
                    hold   <= hold_next;
                    filled <= filled_next;
                    pend   <= pend_next;
                    if (full) begin
                        frame_digits <= hold_next;
                        frame_err    <= pend_next | any_bad;
                        frame_valid  <= 1'b1;
                        state        <= ST_EMIT;
                    end else if (accept) begin
                        state <= ST_COLLECT;
                    end
                end
                default: begin
                    filled <= '0;
                    pend   <= 1'b0;
                    state  <= ST_SYNC;
                end
            endcase
        end
    end

    assign fsm_state = state;

`ifdef SEG_DECODE_DP_EN
    logic [DIGITS-1:0] hold_dp, hold_dp_next;

    always_comb begin
        hold_dp_next = hold_dp;
        for (int i = 0; i < DIGITS; i++) begin
            if (accept && s_sel[i]) hold_dp_next[i] = ~s_seg[7];
        end
    end

    always_ff @(posedge clk) begin
        if (ac) begin
            hold_dp  <= '0;
            frame_dp <= '0;
        end else begin
            hold_dp <= hold_dp_next;
            if (full) frame_dp <= hold_dp_next;
        end
    end
`else
    assign frame_dp = '0;
`endif

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: glyph vector table, directed frame sequences and
// randomized streams checked against a run-level frame model.
module tb_seg_frame_decoder;

    localparam int D  = 8;
    localparam int S  = 4;
    localparam int FW = 1 + D + 5 * D;

`ifdef SEG_DECODE_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    localparam logic [6:0] GLYPHS [0:17] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
        7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E, 7'h2F, 7'h7F};

    localparam logic [39:0] CLEAN_DIG = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

    typedef struct {
        logic [7:0] seg;
        logic [4:0] code;
        logic       dp;
        logic       err;
    } vec_t;

    logic             clk = 1'b0;
    logic             ac;
    logic [D-1:0]     dig_sel;
    logic [7:0]       seg_in;
    logic             frame_valid;
    logic [5*D-1:0]   frame_digits;
    logic [D-1:0]     frame_dp;
    logic             frame_err;
    logic [1:0]       fsm_state;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] act_q[$];

    // Run-level reference model state
    logic [D-1:0] r_sel;
    logic [7:0]   r_seg;
    logic [7:0]   r_raw;
    int           r_len;
    bit           r_done;
    bit           m_collect;
    logic [D-1:0] m_filled;
    logic [4:0]   m_code [D];
    logic [D-1:0] m_dp;
    bit           m_pend;

    seg_frame_decoder #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
        .clk          (clk),
        .ac           (ac),
        .dig_sel      (dig_sel),
        .seg_in       (seg_in),
        .frame_valid  (frame_valid),
        .frame_digits (frame_digits),
        .frame_dp     (frame_dp),
        .frame_err    (frame_err),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) act_q.push_back({frame_err, frame_dp, frame_digits});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] decode_ref(input logic [6:0] pat);
        for (int c = 0; c < 18; c++) begin
            if (GLYPHS[c] == pat) return 5'(c);
        end
        return 5'd31;
    endfunction

    task automatic model_commit(input logic [D-1:0] sel, input logic [7:0] seg);
        int k;
        logic [FW-1:0] fr;
        if (sel == '0) return;
        if ($countones(sel) != 1) begin
            if (m_collect) m_pend = 1'b1;
            return;
        end
        k = 0;
        for (int j = 0; j < D; j++) if (sel[j]) k = j;
        if (!m_collect) begin
            if (k != 0) return;
            m_collect = 1'b1;
            m_filled  = '0;
            m_pend    = 1'b0;
        end else if (m_filled[k]) begin
            m_pend = 1'b1;
        end
        m_code[k]   = decode_ref(seg[6:0]);
        m_dp[k]     = DP_EN && !seg[7];
        m_filled[k] = 1'b1;
        if (&m_filled) begin
            fr = '0;
            fr[FW-1] = m_pend;
            for (int j = 0; j < D; j++) begin
                fr[5*j +: 5] = m_code[j];
                fr[5*D + j]  = m_dp[j];
                if (m_code[j] == 5'd31) fr[FW-1] = 1'b1;
            end
            exp_q.push_back(fr);
            m_collect = 1'b0;
            m_filled  = '0;
            m_pend    = 1'b0;
        end
    endtask

    // Hold one bus value for n cycles; called and returns on a falling edge.
    task automatic drive(input logic [D-1:0] sel, input logic [7:0] seg, input int n);
        logic [7:0] mseg;
        dig_sel = sel;
        seg_in  = seg;
        mseg = DP_EN ? seg : {1'b0, seg[6:0]};
        if (sel == r_sel && mseg == r_seg) begin
            r_len += n;
        end else begin
            r_sel  = sel;
            r_seg  = mseg;
            r_raw  = seg;
            r_len  = n;
            r_done = 1'b0;
        end
        if (!r_done && r_len >= S) begin
            r_done = 1'b1;
            model_commit(r_sel, r_raw);
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        dig_sel = '0;
        seg_in  = 8'hFF;
        ac      = 1'b1;
        @(negedge clk);
        check("reset valid", 64'(frame_valid), 64'd0);
        check("reset digits", 64'(frame_digits), 64'({D{5'd17}}));
        check("reset dp", 64'(frame_dp), 64'd0);
        check("reset err", 64'(frame_err), 64'd0);
        check("reset state", 64'(fsm_state), 64'd0);
        @(negedge clk);
        ac = 1'b0;
        r_sel = '0; r_seg = 8'hFF; r_raw = 8'hFF; r_len = 0; r_done = 1'b1;
        m_collect = 1'b0; m_filled = '0; m_pend = 1'b0; m_dp = '0;
    endtask

    task automatic compare_frames(input string name);
        check({name, " count"}, 64'(act_q.size()), 64'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) check(name, act_q.pop_front(), exp_q.pop_front());
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_one(input string name, input logic [FW-1:0] want);
        check({name, " frames"}, 64'(act_q.size()), 64'd1);
        check({name, " const"}, (act_q.size() > 0) ? 64'(act_q[0]) : 64'd0, 64'(want));
        compare_frames(name);
    endtask

    task automatic slot(input int i, input int c);
        drive(8'(1 << i), {1'b1, GLYPHS[c]}, S);
    endtask

    function automatic logic [7:0] rand_seg();
        logic [6:0] pat;
        if ($urandom_range(0, 7) == 0) pat = 7'($urandom);
        else pat = GLYPHS[$urandom_range(0, 17)];
        return {1'($urandom), pat};
    endfunction

    initial begin
        vec_t vecs [22];
        vecs = '{
            '{8'hC0, 5'd0, 1'b0, 1'b0},  '{8'hF9, 5'd1, 1'b0, 1'b0},  '{8'hA4, 5'd2, 1'b0, 1'b0},
            '{8'hB0, 5'd3, 1'b0, 1'b0},  '{8'h99, 5'd4, 1'b0, 1'b0},  '{8'h92, 5'd5, 1'b0, 1'b0},
            '{8'h82, 5'd6, 1'b0, 1'b0},  '{8'hF8, 5'd7, 1'b0, 1'b0},  '{8'h80, 5'd8, 1'b0, 1'b0},
            '{8'h90, 5'd9, 1'b0, 1'b0},  '{8'h88, 5'd10, 1'b0, 1'b0}, '{8'h83, 5'd11, 1'b0, 1'b0},
            '{8'hA7, 5'd12, 1'b0, 1'b0}, '{8'hA1, 5'd13, 1'b0, 1'b0}, '{8'h86, 5'd14, 1'b0, 1'b0},
            '{8'h8E, 5'd15, 1'b0, 1'b0}, '{8'hAF, 5'd16, 1'b0, 1'b0}, '{8'hFF, 5'd17, 1'b0, 1'b0},
            '{8'hD5, 5'd31, 1'b0, 1'b1}, '{8'h7E, 5'd31, 1'b1, 1'b1}, '{8'h06, 5'd14, 1'b1, 1'b0},
            '{8'h40, 5'd0, 1'b1, 1'b0}
        };

        do_reset();

        // Clean frame with pulse timing
        for (int i = 0; i < D - 1; i++) slot(i, i + 1);
        slot(D - 1, D);
        check("latency early", 64'(frame_valid), 64'd0);
        drive('0, 8'hFF, 1);
        check("latency pulse", 64'(frame_valid), 64'd1);
        check("latency digits", 64'(frame_digits), 64'(CLEAN_DIG));
        drive('0, 8'hFF, 1);
        check("pulse width", 64'(frame_valid), 64'd0);
        drive('0, 8'hFF, 2);
        check("hold digits", 64'(frame_digits), 64'(CLEAN_DIG));
        expect_one("clean", {1'b0, 8'h00, CLEAN_DIG});

        // Blanking gaps and short glitches
        for (int i = 0; i < D; i++) begin
            drive('0, 8'hFF, 2);
            drive(8'(1 << ((i + 3) % D)), {1'b1, GLYPHS[5]}, 3);
            drive(8'(1 << i), {1'b1, GLYPHS[0]}, 2);
            slot(i, i + 1);
        end
        drive('0, 8'hFF, 3);
        expect_one("glitch", {1'b0, 8'h00, CLEAN_DIG});

        // Invalid glyph and decimal point
        for (int i = 0; i < D; i++) begin
            if (i == 3) drive(8'h08, 8'h55, S);
            else if (i == 5) drive(8'h20, 8'h06, S);
            else slot(i, i + 1);
        end
        drive('0, 8'hFF, 3);
        expect_one("err dp", {1'b1, DP_EN ? 8'h28 : 8'h00,
                              5'd8, 5'd7, 5'd14, 5'd5, 5'd31, 5'd3, 5'd2, 5'd1});

        // Stream starting mid-frame
        for (int i = 4; i < D; i++) slot(i, i + 1);
        drive('0, 8'hFF, 3);
        check("align none", 64'(act_q.size()), 64'd0);
        for (int i = 0; i < D; i++) slot(i, i + 1);
        drive('0, 8'hFF, 3);
        expect_one("align", {1'b0, 8'h00, CLEAN_DIG});

        // Duplicate slot
        slot(0, 1); slot(1, 2); slot(2, 9); slot(3, 4); slot(2, 10);
        for (int i = 4; i < D; i++) slot(i, i + 1);
        drive('0, 8'hFF, 3);
        expect_one("dup", {1'b1, 8'h00, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd10, 5'd2, 5'd1});

        // Multi-hot select while collecting
        for (int i = 0; i < 4; i++) slot(i, i + 1);
        drive(8'h11, 8'hC0, S + 1);
        for (int i = 4; i < D; i++) slot(i, i + 1);
        drive('0, 8'hFF, 3);
        expect_one("bad sel", {1'b1, 8'h00, CLEAN_DIG});

        // Reset mid-frame
        for (int i = 0; i < 6; i++) slot(i, i + 1);
        drive('0, 8'hFF, 2);
        do_reset();
        slot(6, 7); slot(7, 8);
        drive('0, 8'hFF, 3);
        check("post reset none", 64'(act_q.size()), 64'd0);
        for (int i = 0; i < D; i++) slot(i, i + 1);
        drive('0, 8'hFF, 3);
        expect_one("post reset", {1'b0, 8'h00, CLEAN_DIG});

        // Glyph table: every slot shows the same pattern
        foreach (vecs[v]) begin
            for (int i = 0; i < D; i++) drive(8'(1 << i), vecs[v].seg, S);
            drive('0, 8'hFF, 3);
            check("table frames", 64'(act_q.size()), 64'd1);
            check($sformatf("table %02h", vecs[v].seg), (act_q.size() > 0) ? 64'(act_q[0]) : 64'd0,
                  64'({vecs[v].err, (DP_EN && vecs[v].dp) ? 8'hFF : 8'h00, {D{vecs[v].code}}}));
            act_q.delete();
            exp_q.delete();
        end

        // Randomized streams against the model
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(0, 3) == 0) drive(8'($urandom), rand_seg(), $urandom_range(1, S - 1));
                if ($urandom_range(0, 1) == 0) drive('0, 8'hFF, $urandom_range(1, 2));
                if ($urandom_range(0, 15) == 0) drive(8'h81, rand_seg(), S);
                drive(8'(1 << i), rand_seg(), $urandom_range(S, S + 2));
                if (i >= 2 && $urandom_range(0, 9) == 0) drive(8'(1 << (i - 1)), rand_seg(), S);
            end
            drive('0, 8'hFF, 3);
        end
        compare_frames("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
